// File: rtl/washer_ctrl.sv
// Washing-machine sequencer: IDLE-FILL-WASH-DRAIN-FILL2-RINSE-SPIN with load-scaled phase timing.
// Optional WASHER_EXTRA_RINSE_EN inserts DRAIN2/FILL3/RINSE2 between RINSE and SPIN.
module washer_ctrl #(
  parameter int FILL_BASE  = 4,
  parameter int WASH_BASE  = 6,
  parameter int DRAIN_T    = 3,
  parameter int RINSE_BASE = 4,
  parameter int SPIN_T     = 5,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Door,
  input  logic [1:0] load,
  output logic       Agitator,
  output logic       Motor,
  output logic       Pump,
  output logic       Speed,
  output logic       Water,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_WASH   = 4'd2,
    S_DRAIN  = 4'd3,
    S_FILL2  = 4'd4,
    S_RINSE  = 4'd5,
    S_DRAIN2 = 4'd6,
    S_FILL3  = 4'd7,
    S_RINSE2 = 4'd8,
    S_SPIN   = 4'd9
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       lat, lat_n;
  logic             legal_run;

  // Timer reload value (phase length minus one) for a phase at latched load l.
  function automatic logic [CNT_W-1:0] phase_last(input state_t s, input logic [1:0] l);
    logic [CNT_W-1:0] lx;
    lx = CNT_W'(l);
    case (s)
      S_FILL, S_FILL2, S_FILL3: phase_last = CNT_W'(FILL_BASE) + lx - CNT_W'(1);
      S_WASH:                   phase_last = CNT_W'(WASH_BASE) + lx - CNT_W'(1);
      S_RINSE, S_RINSE2:        phase_last = CNT_W'(RINSE_BASE) + lx - CNT_W'(1);
      S_DRAIN, S_DRAIN2:        phase_last = CNT_W'(DRAIN_T - 1);
      S_SPIN:                   phase_last = CNT_W'(SPIN_T - 1);
      default:                  phase_last = '0;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      S_FILL:   next_phase = S_WASH;
      S_WASH:   next_phase = S_DRAIN;
      S_DRAIN:  next_phase = S_FILL2;
      S_FILL2:  next_phase = S_RINSE;
`ifdef WASHER_EXTRA_RINSE_EN
      S_RINSE:  next_phase = S_DRAIN2;
      S_DRAIN2: next_phase = S_FILL3;
      S_FILL3:  next_phase = S_RINSE2;
      S_RINSE2: next_phase = S_SPIN;
`else
      S_RINSE:  next_phase = S_SPIN;
`endif
      default:  next_phase = S_IDLE;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      lat   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lat   <= lat_n;
    end
  end

  always_comb begin
    legal_run = 1'b0;
    case (state)
      S_FILL, S_WASH, S_DRAIN, S_FILL2, S_RINSE, S_SPIN: legal_run = 1'b1;
`ifdef WASHER_EXTRA_RINSE_EN
      S_DRAIN2, S_FILL3, S_RINSE2:                       legal_run = 1'b1;
`endif
      default:                                           legal_run = 1'b0;
    endcase
  end

  // An open door freezes both state and timer so the phase resumes where it stopped.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lat_n   = lat;
    if (state == S_IDLE) begin
      if (Start && !Door) begin
        lat_n   = (load == 2'b11) ? 2'b10 : load;
        state_n = S_FILL;
        cnt_n   = phase_last(S_FILL, lat_n);
      end
    end else if (legal_run) begin
      if (!Door) begin
        if (cnt == '0) begin
          state_n = next_phase(state);
          cnt_n   = phase_last(state_n, lat);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
    end else begin
      state_n = S_IDLE;
      cnt_n   = '0;
      lat_n   = '0;
    end
  end

  always_comb begin
    Agitator = 1'b0;
    Motor    = 1'b0;
    Pump     = 1'b0;
    Speed    = 1'b0;
    Water    = 1'b0;
    if (!Door) begin
      case (state)
        S_FILL, S_FILL2, S_FILL3: Water = 1'b1;
        S_WASH, S_RINSE, S_RINSE2: begin
          Agitator = 1'b1;
          Motor    = 1'b1;
        end
        S_DRAIN, S_DRAIN2: Pump = 1'b1;
        S_SPIN: begin
          Pump  = 1'b1;
          Motor = 1'b1;
          Speed = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_washer_ctrl.sv
// Self-checking bench for washer_ctrl: per-cycle actuator patterns from a phase-list model,
// randomized Start/load noise, door pauses, back-to-back cycles and async reset.
module tb_washer_ctrl;

  localparam int FB = 4;
  localparam int WB = 6;
  localparam int DT = 3;
  localparam int RB = 4;
  localparam int ST = 5;

  // Pattern order: {Agitator, Motor, Pump, Speed, Water}
  localparam logic [4:0] P_OFF   = 5'b00000;
  localparam logic [4:0] P_WATER = 5'b00001;
  localparam logic [4:0] P_AGIT  = 5'b11000;
  localparam logic [4:0] P_PUMP  = 5'b00100;
  localparam logic [4:0] P_SPIN  = 5'b01110;

  logic       clk = 1'b0;
  logic       reset;
  logic       Start;
  logic       Door;
  logic [1:0] load;
  logic       Agitator, Motor, Pump, Speed, Water;
  logic [3:0] state_dbg;
  logic [4:0] obs;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  washer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Door      (Door),
    .load      (load),
    .Agitator  (Agitator),
    .Motor     (Motor),
    .Pump      (Pump),
    .Speed     (Speed),
    .Water     (Water),
    .state_dbg (state_dbg)
  );

  assign obs = {Agitator, Motor, Pump, Speed, Water};

  task automatic push_phase(input logic [4:0] pat, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pat);
  endtask

  task automatic build_seq(input logic [1:0] l);
    int lm;
    lm = (l > 2'd2) ? 2 : int'(l);
    push_phase(P_WATER, FB + lm);
    push_phase(P_AGIT,  WB + lm);
    push_phase(P_PUMP,  DT);
    push_phase(P_WATER, FB + lm);
    push_phase(P_AGIT,  RB + lm);
`ifdef WASHER_EXTRA_RINSE_EN
    push_phase(P_PUMP,  DT);
    push_phase(P_WATER, FB + lm);
    push_phase(P_AGIT,  RB + lm);
`endif
    push_phase(P_SPIN,  ST);
  endtask

  task automatic kick(input logic [1:0] l);
    load  = l;
    Door  = 1'b0;
    Start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Walks exp_q one cycle at a time; door-open cycles expect all-off and consume nothing.
  task automatic play(input string name, input int door_at, input int door_len,
                      input int start_hold, input int fix_at, input logic [1:0] fix_load,
                      input int limit);
    int c;
    logic [4:0] e;
    bit dopen;
    c = 0;
    while (exp_q.size() > 0 && c < limit) begin
      dopen = (c >= door_at) && (c < door_at + door_len);
      Door  = dopen;
      Start = (c < start_hold) ? 1'b1 : ($urandom_range(0, 3) == 0);
      load  = (c == fix_at) ? fix_load : 2'($urandom_range(0, 3));
      @(negedge clk);
      if (dopen) e = P_OFF;
      else       e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs %b expected %b", name, c, obs, e);
      end
      @(posedge clk);
      #1;
      c++;
    end
    Door  = 1'b0;
    Start = 1'b0;
  endtask

  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      Start = 1'b0;
      Door  = 1'($urandom_range(0, 1));
      load  = 2'($urandom_range(0, 3));
      @(negedge clk);
      checks++;
      if (obs !== P_OFF) begin
        errors++;
        $display("FAIL %s idle %0d: outputs %b expected %b", name, i, obs, P_OFF);
      end
      @(posedge clk);
      #1;
    end
    Door = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    Start = 1'b1;
    Door  = 1'b0;
    load  = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== P_OFF) begin
        errors++;
        $display("FAIL reset cycle %0d: outputs %b expected %b", i, obs, P_OFF);
      end
    end
    Start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle("after_reset", 3);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load(input string name, input logic [1:0] l);
    exp_q.delete();
    kick(l);
    build_seq(l);
    play(name, -1, 0, 0, -1, 2'b00, 1000);
    check_idle(name, 3);
  endtask

  task automatic test_door_spin();
    int n;
    exp_q.delete();
    kick(2'b10);
    build_seq(2'b10);
    n = exp_q.size();
    play("door_spin", n - 2, 2, 0, -1, 2'b00, 1000);
    check_idle("door_spin", 3);
  endtask

  task automatic test_random_door();
    logic [1:0] l;
    int n, at, len;
    for (int k = 0; k < 6; k++) begin
      exp_q.delete();
      l = 2'($urandom_range(0, 3));
      kick(l);
      build_seq(l);
      n   = exp_q.size();
      at  = $urandom_range(0, n - 1);
      len = $urandom_range(1, 4);
      play("random_door", at, len, 0, -1, 2'b00, 1000);
      check_idle("random_door", 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] l1, l2;
    int n1;
    exp_q.delete();
    l1 = 2'($urandom_range(0, 3));
    l2 = 2'($urandom_range(0, 3));
    kick(l1);
    build_seq(l1);
    n1 = exp_q.size();
    exp_q.push_back(P_OFF);
    build_seq(l2);
    play("back_to_back", -1, 0, n1 + 1, n1, l2, 1000);
    check_idle("back_to_back", 3);
  endtask

  task automatic test_reset_mid_wash();
    exp_q.delete();
    kick(2'b00);
    build_seq(2'b00);
    play("pre_reset", -1, 0, 0, -1, 2'b00, FB + 2);
    checks++;
    if (obs !== P_AGIT) begin
      errors++;
      $display("FAIL mid_wash before reset: outputs %b expected %b", obs, P_AGIT);
    end
    exp_q.delete();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== P_OFF) begin
      errors++;
      $display("FAIL mid_wash async reset: outputs %b expected %b", obs, P_OFF);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs !== P_OFF) begin
        errors++;
        $display("FAIL mid_wash held reset: outputs %b expected %b", obs, P_OFF);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle("mid_wash_release", 3);
  endtask

  task automatic test_door_start_idle();
    for (int i = 0; i < 4; i++) begin
      Door  = 1'b1;
      Start = 1'b1;
      load  = 2'($urandom_range(0, 3));
      @(negedge clk);
      checks++;
      if (obs !== P_OFF) begin
        errors++;
        $display("FAIL door_start_idle cycle %0d: outputs %b expected %b", i, obs, P_OFF);
      end
      @(posedge clk);
      #1;
    end
    Start = 1'b0;
    Door  = 1'b0;
    check_idle("door_start_idle", 4);
  endtask

  initial begin
    reset = 1'b0;
    Start = 1'b0;
    Door  = 1'b0;
    load  = 2'b00;
    test_reset();
    test_load("small", 2'b00);
    reset_pulse();
    test_load("medium", 2'b01);
    test_load("large", 2'b10);
    test_load("load3", 2'b11);
    test_door_spin();
    test_random_door();
    test_back_to_back();
    test_reset_mid_wash();
    test_door_start_idle();
    test_load("final_small", 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
